bram_burst_responder: RTL and testbench

Responder end of the user-side burst memory interface: answers `rd_burst_req`/`wr_burst_req` from a burst initiator (such as the memory test generator) using on-chip block RAM instead of external SDRAM. It drops in where the SDRAM controller would sit, so initiator logic can be exercised on-chip and in simulation without the SDRAM device or its PLL. Access delay is programmable to mimic SDRAM activate/CAS latency.

---
 rtl/burst_if_pkg.sv | 21 ++
 rtl/burst_resp_ram.sv | 28 ++
 rtl/bram_burst_responder.sv | 168 ++++++++++++++++
 tb/tb_bram_burst_responder.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/burst_if_pkg.sv
// Shared definitions for the user-side burst memory interface: FSM state
// encoding, default port widths and the largest supported access delay.
package burst_if_pkg;

  localparam int DEF_MEM_DATA_BITS = 16;
  localparam int DEF_ADDR_BITS     = 24;
  localparam int DEF_BURST_BITS    = 10;
  localparam int ACCESS_DELAY_MAX  = 15;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DELAY,
    ST_RD,
    ST_RD_TAIL,
    ST_WR,
    ST_WR_TAIL,
    ST_FINISH,
    ST_GAP
  } burst_state_e;

endpackage

// File: rtl/burst_resp_ram.sv
// Simple dual-port block RAM: one write port, one registered read port.
// No reset on the array or the read register so the tools map it to BRAM.
module burst_resp_ram #(
  parameter int DATA_BITS = 16,
  parameter int ADDR_BITS = 12
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] waddr,
  input  logic [DATA_BITS-1:0] wdata,
  input  logic                 re,
  input  logic [ADDR_BITS-1:0] raddr,
  output logic [DATA_BITS-1:0] rdata
);

  logic [DATA_BITS-1:0] mem [0:(1<<ADDR_BITS)-1];

  // Write port: one word per enabled cycle.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read port: data appears the cycle after the read is issued.
  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/bram_burst_responder.sv
// Burst responder backed by on-chip RAM. Stands in for the SDRAM controller
// on the user-side burst interface; ACCESS_DELAY idle cycles mimic SDRAM
// activate/CAS latency. Read wins when both requests arrive together.
// Optional build macro BRAM_BURST_RESPONDER_ERRINJ_EN adds an err_inject
// input that flips bit 0 of read data on the beats where it is high.
module bram_burst_responder
  import burst_if_pkg::*;
#(
  parameter int MEM_DATA_BITS = DEF_MEM_DATA_BITS,
  parameter int ADDR_BITS     = DEF_ADDR_BITS,
  parameter int BUSRT_BITS    = DEF_BURST_BITS,
  parameter int RAM_ADDR_BITS = 12,
  parameter int ACCESS_DELAY  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
`ifdef BRAM_BURST_RESPONDER_ERRINJ_EN
  input  logic                     err_inject,
`endif
  input  logic                     rd_burst_req,
  input  logic [BUSRT_BITS-1:0]    rd_burst_len,
  input  logic [ADDR_BITS-1:0]     rd_burst_addr,
  output logic                     rd_burst_data_valid,
  output logic [MEM_DATA_BITS-1:0] rd_burst_data,
  output logic                     rd_burst_finish,
  input  logic                     wr_burst_req,
  input  logic [BUSRT_BITS-1:0]    wr_burst_len,
  input  logic [ADDR_BITS-1:0]     wr_burst_addr,
  output logic                     wr_burst_data_req,
  input  logic [MEM_DATA_BITS-1:0] wr_burst_data,
  output logic                     wr_burst_finish
);

  // Delay is clamped to what the 4-bit counter can express.
  localparam int DLY_CYCLES = (ACCESS_DELAY > ACCESS_DELAY_MAX) ? ACCESS_DELAY_MAX : ACCESS_DELAY;
  localparam int DLY_LAST   = (DLY_CYCLES > 0) ? DLY_CYCLES - 1 : 0;

  burst_state_e state, state_nxt;

  logic                     is_rd;
  logic [RAM_ADDR_BITS-1:0] base_addr;
  logic [BUSRT_BITS-1:0]    len_q;
  logic [BUSRT_BITS-1:0]    beat_cnt;
  logic [3:0]               dly_cnt;

  logic                     accept_rd;
  logic                     accept_wr;
  logic [BUSRT_BITS-1:0]    accept_len;
  logic                     issue_rd;
  logic                     issue_wr;
  logic                     last_beat;
  logic [RAM_ADDR_BITS-1:0] issue_addr;

  logic                     rd_vld_p1;
  logic                     wr_pend_p1;
  logic [RAM_ADDR_BITS-1:0] wr_addr_p1;
  logic [MEM_DATA_BITS-1:0] ram_q;

  // Address bits above the RAM depth alias by design.
  logic unused_addr_hi;
  assign unused_addr_hi = ^{rd_burst_addr[ADDR_BITS-1:RAM_ADDR_BITS],
                            wr_burst_addr[ADDR_BITS-1:RAM_ADDR_BITS]};

  assign accept_rd  = (state == ST_IDLE) && rd_burst_req;
  assign accept_wr  = (state == ST_IDLE) && !rd_burst_req && wr_burst_req;
  assign accept_len = rd_burst_req ? rd_burst_len : wr_burst_len;
  assign last_beat  = (beat_cnt == len_q - BUSRT_BITS'(1));
  assign issue_addr = base_addr + RAM_ADDR_BITS'(beat_cnt);

  // Next-state decode and Moore outputs.
  always_comb begin
    state_nxt       = state;
    issue_rd        = 1'b0;
    issue_wr        = 1'b0;
    rd_burst_finish = 1'b0;
    wr_burst_finish = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept_rd || accept_wr) begin
          if (DLY_CYCLES != 0)       state_nxt = ST_DELAY;
          else if (accept_len == '0) state_nxt = ST_FINISH;
          else if (accept_rd)        state_nxt = ST_RD;
          else                       state_nxt = ST_WR;
        end
      end
      ST_DELAY: begin
        if (dly_cnt == 4'(DLY_LAST)) begin
          if (len_q == '0) state_nxt = ST_FINISH;
          else if (is_rd)  state_nxt = ST_RD;
          else             state_nxt = ST_WR;
        end
      end
      ST_RD: begin
        issue_rd = 1'b1;
        if (last_beat) state_nxt = ST_RD_TAIL;
      end
      ST_RD_TAIL: state_nxt = ST_FINISH;
      ST_WR: begin
        issue_wr = 1'b1;
        if (last_beat) state_nxt = ST_WR_TAIL;
      end
      ST_WR_TAIL: state_nxt = ST_FINISH;
      ST_FINISH: begin
        rd_burst_finish = is_rd;
        wr_burst_finish = !is_rd;
        state_nxt       = ST_GAP;
      end
      ST_GAP:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign wr_burst_data_req = issue_wr;

  // Control registers: state, counters, direction and pipeline valids.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      is_rd      <= 1'b0;
      dly_cnt    <= '0;
      beat_cnt   <= '0;
      rd_vld_p1  <= 1'b0;
      wr_pend_p1 <= 1'b0;
    end else begin
      state      <= state_nxt;
      if (accept_rd || accept_wr) is_rd <= accept_rd;
      dly_cnt    <= (state == ST_DELAY) ? dly_cnt + 4'd1 : 4'd0;
      beat_cnt   <= (issue_rd || issue_wr) ? beat_cnt + BUSRT_BITS'(1) : '0;
      rd_vld_p1  <= issue_rd;
      wr_pend_p1 <= issue_wr;
    end
  end

  // Data registers: burst parameters captured at acceptance, write address
  // delayed one cycle to line up with the beat the initiator presents.
  always_ff @(posedge clk) begin
    if (accept_rd) begin
      base_addr <= rd_burst_addr[RAM_ADDR_BITS-1:0];
      len_q     <= rd_burst_len;
    end else if (accept_wr) begin
      base_addr <= wr_burst_addr[RAM_ADDR_BITS-1:0];
      len_q     <= wr_burst_len;
    end
    wr_addr_p1 <= issue_addr;
  end

  // ---- p1: RAM access; read data returns, write beat is committed ----
  burst_resp_ram #(
    .DATA_BITS(MEM_DATA_BITS),
    .ADDR_BITS(RAM_ADDR_BITS)
  ) u_ram (
    .clk  (clk),
    .we   (wr_pend_p1),
    .waddr(wr_addr_p1),
    .wdata(wr_burst_data),
    .re   (issue_rd),
    .raddr(issue_addr),
    .rdata(ram_q)
  );

  assign rd_burst_data_valid = rd_vld_p1;
`ifdef BRAM_BURST_RESPONDER_ERRINJ_EN
  assign rd_burst_data = rd_vld_p1 ? (ram_q ^ MEM_DATA_BITS'(err_inject)) : '0;
`else
  assign rd_burst_data = rd_vld_p1 ? ram_q : '0;
`endif

endmodule

// File: tb/tb_bram_burst_responder.sv
// Bench for bram_burst_responder: directed scenarios plus randomized bursts,
// checked against a word-array memory model and cycle-count timing rules.
module tb_bram_burst_responder;

  localparam int AD    = 4;
  localparam int DEPTH = 4096;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_burst_req;
  logic [9:0]  rd_burst_len;
  logic [23:0] rd_burst_addr;
  logic        rd_burst_data_valid;
  logic [15:0] rd_burst_data;
  logic        rd_burst_finish;
  logic        wr_burst_req;
  logic [9:0]  wr_burst_len;
  logic [23:0] wr_burst_addr;
  logic        wr_burst_data_req;
  logic [15:0] wr_burst_data;
  logic        wr_burst_finish;
`ifdef BRAM_BURST_RESPONDER_ERRINJ_EN
  logic        err_inject = 1'b0;
`endif

  always #5 clk = ~clk;

  bram_burst_responder #(
    .MEM_DATA_BITS(16), .ADDR_BITS(24), .BUSRT_BITS(10),
    .RAM_ADDR_BITS(12), .ACCESS_DELAY(AD)
  ) dut (
    .clk                (clk),
`ifdef BRAM_BURST_RESPONDER_ERRINJ_EN
    .err_inject         (err_inject),
`endif
    .rst                (rst),
    .rd_burst_req       (rd_burst_req),
    .rd_burst_len       (rd_burst_len),
    .rd_burst_addr      (rd_burst_addr),
    .rd_burst_data_valid(rd_burst_data_valid),
    .rd_burst_data      (rd_burst_data),
    .rd_burst_finish    (rd_burst_finish),
    .wr_burst_req       (wr_burst_req),
    .wr_burst_len       (wr_burst_len),
    .wr_burst_addr      (wr_burst_addr),
    .wr_burst_data_req  (wr_burst_data_req),
    .wr_burst_data      (wr_burst_data),
    .wr_burst_finish    (wr_burst_finish)
  );

  logic [15:0] model [0:DEPTH-1];
  logic [15:0] wdata_q [$];
  int total  = 0;
  int passes = 0;
  int fails  = 0;

  // observations from the most recent burst
  int rv_first, rv_cnt, rv_gaps, rd_fin_cyc, rd_fin_cnt;
  int wq_first, wq_cnt, wr_fin_cyc, wr_fin_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
    total++;
  endtask

  task automatic fill_rand(input int n);
    wdata_q.delete();
    for (int i = 0; i < n; i++) wdata_q.push_back(16'($urandom));
  endtask

  task automatic fill_list(input logic [15:0] base, input int n);
    wdata_q.delete();
    for (int i = 0; i < n; i++) wdata_q.push_back(base + 16'(i));
  endtask

  // Runs one read and/or write burst as an initiator would. Cycle 0 is the
  // cycle in which the request(s) are first presented.
  task automatic burst(input bit do_rd, input logic [23:0] ra, input int rl,
                       input bit do_wr, input logic [23:0] wa, input int wl,
                       input int inj);
    int rk, wk, last_v;
    bit req_seen, rfin, wfin;
    logic [15:0] exp_d;
    rk = 0; wk = 0; last_v = -2;
    rv_first = -1; rv_cnt = 0; rv_gaps = 0; rd_fin_cyc = -1; rd_fin_cnt = 0;
    wq_first = -1; wq_cnt = 0; wr_fin_cyc = -1; wr_fin_cnt = 0;
    @(posedge clk); #1;
    rd_burst_req = do_rd; rd_burst_addr = ra; rd_burst_len = 10'(rl);
    wr_burst_req = do_wr; wr_burst_addr = wa; wr_burst_len = 10'(wl);
    for (int c = 0; c < 400; c++) begin
      if ((!do_rd || rd_fin_cnt > 0) && (!do_wr || wr_fin_cnt > 0)) break;
      @(negedge clk);
`ifdef BRAM_BURST_RESPONDER_ERRINJ_EN
      err_inject = (rk == inj);
`endif
      #1;
      if (rd_burst_data_valid) begin
        if (rv_first < 0) rv_first = c;
        else if (last_v != c - 1) rv_gaps++;
        last_v = c;
        rv_cnt++;
        exp_d = model[(int'(ra) + rk) % DEPTH];
        if (rk == inj) exp_d[0] = ~exp_d[0];
        chk("rd_beat", 32'(rd_burst_data), 32'(exp_d));
        rk++;
      end
      rfin = rd_burst_finish; wfin = wr_burst_finish; req_seen = wr_burst_data_req;
      if (rfin) begin rd_fin_cnt++; rd_fin_cyc = c; end
      if (wfin) begin wr_fin_cnt++; wr_fin_cyc = c; end
      if (req_seen) begin
        if (wq_first < 0) wq_first = c;
        wq_cnt++;
      end
      @(posedge clk); #1;
      if (req_seen && wk < wdata_q.size()) begin
        wr_burst_data = wdata_q[wk];
        model[(int'(wa) + wk) % DEPTH] = wdata_q[wk];
        wk++;
      end
      if (rfin) rd_burst_req = 1'b0;
      if (wfin) wr_burst_req = 1'b0;
    end
`ifdef BRAM_BURST_RESPONDER_ERRINJ_EN
    err_inject = 1'b0;
`endif
    chk("burst_done", {30'd0, (!do_rd || rd_fin_cnt > 0), (!do_wr || wr_fin_cnt > 0)}, 32'd3);
  endtask

  task automatic check_rd(input string tag, input int rl, input int acc);
    if (rl == 0) begin
      chk({tag, "_nvalid"}, rv_cnt, 0);
      chk({tag, "_fin_cyc"}, rd_fin_cyc, acc + AD + 1);
    end else begin
      chk({tag, "_first"}, rv_first, acc + AD + 2);
      chk({tag, "_nvalid"}, rv_cnt, rl);
      chk({tag, "_gaps"}, rv_gaps, 0);
      chk({tag, "_fin_cyc"}, rd_fin_cyc, acc + AD + 2 + rl);
    end
    chk({tag, "_fin_cnt"}, rd_fin_cnt, 1);
  endtask

  task automatic check_wr(input string tag, input int wl, input int acc);
    chk({tag, "_nreq"}, wq_cnt, wl);
    if (wl == 0) chk({tag, "_fin_cyc"}, wr_fin_cyc, acc + AD + 1);
    else begin
      chk({tag, "_first"}, wq_first, acc + AD + 1);
      chk({tag, "_fin_cyc"}, wr_fin_cyc, acc + AD + wl + 2);
    end
    chk({tag, "_fin_cnt"}, wr_fin_cnt, 1);
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_rvalid"}, rd_burst_data_valid, 0);
    chk({tag, "_rdata"}, rd_burst_data, 0);
    chk({tag, "_rfin"}, rd_burst_finish, 0);
    chk({tag, "_wreq"}, wr_burst_data_req, 0);
    chk({tag, "_wfin"}, wr_burst_finish, 0);
  endtask

  initial begin
    int nreq, wk, seen, ra;
    bit hit, req_seen;
    logic [23:0] a;
    int l;

    rst = 1'b1;
    rd_burst_req = 0; rd_burst_len = '0; rd_burst_addr = '0;
    wr_burst_req = 0; wr_burst_len = '0; wr_burst_addr = '0; wr_burst_data = '0;
    #1;
    check_idle_outputs("reset");
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;

    // Write 0x10..0x17 at 0x10, then read it back
    fill_list(16'h0010, 8);
    burst(0, 0, 0, 1, 24'h000010, 8, -1);
    check_wr("wr8", 8, 0);
    burst(1, 24'h000010, 8, 0, 0, 0, -1);
    check_rd("rd8", 8, 0);

    // Wrap at the top of the RAM and aliasing of high address bits
    wdata_q.delete();
    wdata_q.push_back(16'hA11A); wdata_q.push_back(16'hB22B);
    wdata_q.push_back(16'hC33C); wdata_q.push_back(16'hD44D);
    burst(0, 0, 0, 1, 24'h000FFE, 4, -1);
    check_wr("wr_wrap", 4, 0);
    burst(1, 24'h000FFE, 4, 0, 0, 0, -1);
    check_rd("rd_wrap", 4, 0);
    chk("wrap_model_c", 32'(model[0]), 32'h0000C33C);
    burst(1, 24'h000000, 2, 0, 0, 0, -1);
    check_rd("rd_low", 2, 0);
    burst(1, 24'h001000, 2, 0, 0, 0, -1);
    check_rd("rd_alias", 2, 0);

    // Simultaneous requests: read first, write accepted 2 cycles after its finish
    fill_rand(5);
    burst(1, 24'h000010, 3, 1, 24'h000300, 5, -1);
    check_rd("both_rd", 3, 0);
    check_wr("both_wr", 5, rd_fin_cyc + 2);
    burst(1, 24'h000300, 5, 0, 0, 0, -1);
    check_rd("both_chk", 5, 0);

    // Zero-length bursts
    burst(1, 24'h000040, 0, 0, 0, 0, -1);
    check_rd("rd_len0", 0, 0);
    wdata_q.delete();
    burst(0, 0, 0, 1, 24'h000040, 0, -1);
    check_wr("wr_len0", 0, 0);

    // Reset during beat 3 of an 8-beat write
    fill_rand(8);
    @(posedge clk); #1;
    wr_burst_req = 1; wr_burst_addr = 24'h000200; wr_burst_len = 10'd8;
    nreq = 0; wk = 0; hit = 0;
    for (int c = 0; c < 60 && !hit; c++) begin
      @(negedge clk); #1;
      req_seen = wr_burst_data_req;
      if (req_seen) nreq++;
      @(posedge clk); #1;
      if (req_seen) begin
        wr_burst_data = wdata_q[wk];
        if (wk < 3) model[16'h200 + wk] = wdata_q[wk];
        wk++;
      end
      if (nreq == 4) hit = 1;
    end
    chk("rst_reach_beat3", hit, 1);
    @(negedge clk);
    chk("rst_wreq_before", wr_burst_data_req, 1);
    rst = 1'b1; wr_burst_req = 1'b0;
    #1;
    check_idle_outputs("rst_async");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk); #1;
      if (wr_burst_finish || rd_burst_finish || wr_burst_data_req || rd_burst_data_valid) seen++;
    end
    chk("rst_no_activity", seen, 0);
    burst(1, 24'h000200, 3, 0, 0, 0, -1);
    check_rd("rst_keep", 3, 0);

    // Randomized write/read-back pairs over the full address range
    for (int i = 0; i < 8; i++) begin
      a = 24'($urandom);
      l = $urandom_range(1, 24);
      fill_rand(l);
      burst(0, 0, 0, 1, a, l, -1);
      check_wr("rnd_wr", l, 0);
      ra = $urandom_range(0, l - 1);
      burst(1, a + 24'(ra), l - ra, 0, 0, 0, -1);
      check_rd("rnd_rd", l - ra, 0);
    end

`ifdef BRAM_BURST_RESPONDER_ERRINJ_EN
    // Error injection on beat 2 flips bit 0 only on that beat
    fill_list(16'h0000, 8);
    burst(0, 0, 0, 1, 24'h000000, 8, -1);
    check_wr("inj_wr", 8, 0);
    burst(1, 24'h000000, 8, 0, 0, 0, 2);
    check_rd("inj_rd", 8, 0);
    burst(1, 24'h000002, 1, 0, 0, 0, -1);
    check_rd("inj_ram_intact", 1, 0);
`endif

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
